// File: rtl/rf_wb_queue_if.sv
// Handshake and register-file-side bundle for rf_wb_queue.
// master: producer/decode/control side that drives the requests.
// slave : the writeback queue itself.
interface rf_wb_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 16
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  // producer side
  logic          in_valid;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_ready;

  // register file write port
  logic          wb_stall;
  logic [AW-1:0] dst_addr;
  logic [DW-1:0] dst;
  logic          we;

  // forwarding lookups
  logic [AW-1:0] q0_addr;
  logic [AW-1:0] q1_addr;
  logic          q0_hit;
  logic          q1_hit;
  logic [DW-1:0] q0_data;
  logic [DW-1:0] q1_data;

  // halt / status
  logic          hlt;
  logic          drained;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_addr, in_data, wb_stall, q0_addr, q1_addr, hlt,
    input  in_ready, dst_addr, dst, we, q0_hit, q1_hit, q0_data, q1_data,
           drained, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, wb_stall, q0_addr, q1_addr, hlt,
    output in_ready, dst_addr, dst, we, q0_hit, q1_hit, q0_data, q1_data,
           drained, count
  );
endinterface

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: writeback FIFO in front of the register file write port.
// Buffers {addr, data} results, drains one per cycle, offers two
// forwarding lookups, and runs a halt-drain sequence (RUN/DRAIN/HALTED).
// Optional feature macro: RF_WB_BYPASS_EN builds the forwarding compare
// logic; when undefined the lookup outputs are tied to zero.
module rf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input logic           clk,
  input logic           rst_n,
  rf_wb_queue_if.slave  q_if
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic pop_s;
  logic ready_s;
  logic push_s;
  logic store_s;

  // Handshake decisions: pop when non-empty and not stalled; accept while running and not full (or freeing a slot)
  always_comb begin
    pop_s   = (count_q != {CW{1'b0}}) && !q_if.wb_stall;
    ready_s = (state_q == RUN) && ((count_q < CW'(DEPTH)) || pop_s);
    push_s  = q_if.in_valid && ready_s;
    // R0 is hardwired zero: the handshake completes but nothing is stored
    store_s = push_s && (q_if.in_addr != {AW{1'b0}});
  end

  // Next pointer and occupancy values
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_s) begin
      head_d = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end
    if (store_s) begin
      tail_d = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end
    case ({store_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Halt sequencing; DRAIN ends on the edge that leaves the queue empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (q_if.hlt) state_d = DRAIN;
        else          state_d = RUN;
      end
      DRAIN: begin
        if (count_d == {CW{1'b0}}) state_d = HALTED;
        else                       state_d = DRAIN;
      end
      HALTED: begin
        if (!q_if.hlt) state_d = RUN;
        else           state_d = HALTED;
      end
      default: state_d = RUN;
    endcase
  end

  // Control registers: pointers, occupancy and halt state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: write the accepted result at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {AW{1'b0}};
        data_q[i] <= {DW{1'b0}};
      end
    end else if (store_s) begin
      addr_q[tail_q] <= q_if.in_addr;
      data_q[tail_q] <= q_if.in_data;
    end
  end

  // Register file write port shows the head entry, zero when empty
  always_comb begin
    if (count_q != {CW{1'b0}}) begin
      q_if.dst_addr = addr_q[head_q];
      q_if.dst      = data_q[head_q];
    end else begin
      q_if.dst_addr = {AW{1'b0}};
      q_if.dst      = {DW{1'b0}};
    end
  end

  assign q_if.we       = pop_s;
  assign q_if.in_ready = ready_s;
  assign q_if.drained  = (state_q == HALTED);
  assign q_if.count    = count_q;

`ifdef RF_WB_BYPASS_EN
  // Scan valid entries oldest to youngest so the youngest match wins.
  function automatic logic [DW:0] lookup_f(input logic [AW-1:0] a);
    logic [DW:0]   r;
    logic [PW-1:0] idx;
    r = {(DW+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (a != {AW{1'b0}}) && (addr_q[idx] == a)) begin
        r = {1'b1, data_q[idx]};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  logic [DW:0] look0_s;
  logic [DW:0] look1_s;

  // Forwarding lookups for the two decode read ports
  always_comb begin
    look0_s = lookup_f(q_if.q0_addr);
    look1_s = lookup_f(q_if.q1_addr);
  end

  assign q_if.q0_hit  = look0_s[DW];
  assign q_if.q0_data = look0_s[DW-1:0];
  assign q_if.q1_hit  = look1_s[DW];
  assign q_if.q1_data = look1_s[DW-1:0];
`else
  assign q_if.q0_hit  = 1'b0;
  assign q_if.q0_data = {DW{1'b0}};
  assign q_if.q1_hit  = 1'b0;
  assign q_if.q1_data = {DW{1'b0}};
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: directed scenarios with literal
// expectations plus a randomized phase, all outputs compared every cycle
// against a queue-based reference model.
module tb_rf_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 4;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  rf_wb_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  rf_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q_if  (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mq[$];
  int   mst = 0;   // 0 = running, 1 = draining, 2 = halted

  function automatic bit m_we();
    return (mq.size() != 0) && !bus.wb_stall;
  endfunction

  function automatic bit m_ready();
    return (mst == 0) && ((mq.size() < DEPTH) || m_we());
  endfunction

  function automatic logic [DW:0] m_look(input logic [AW-1:0] a);
    if (a == 4'd0) return 17'd0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == a) return {1'b1, mq[i].d};
    end
    return 17'd0;
  endfunction

  task automatic model_edge();
    bit   pop_now;
    bit   push_now;
    ent_t e;
    pop_now  = m_we();
    push_now = bus.in_valid && m_ready() && (bus.in_addr != 4'd0);
    e.a = bus.in_addr;
    e.d = bus.in_data;
    if (pop_now)  void'(mq.pop_front());
    if (push_now) mq.push_back(e);
    case (mst)
      0:       if (bus.hlt) mst = 1;
      1:       if (mq.size() == 0) mst = 2;
      2:       if (!bus.hlt) mst = 0;
      default: mst = 0;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mst <= 0;
    end else begin
      model_edge();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [DW:0] l0, l1;
    chk("we",       {31'd0, bus.we},       {31'd0, m_we()});
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_ready()});
    chk("count",    32'(bus.count),        32'(mq.size()));
    chk("drained",  {31'd0, bus.drained},  {31'd0, (mst == 2)});
    chk("dst_addr", 32'(bus.dst_addr),     (mq.size() != 0) ? 32'(mq[0].a) : 32'd0);
    chk("dst",      32'(bus.dst),          (mq.size() != 0) ? 32'(mq[0].d) : 32'd0);
`ifdef RF_WB_BYPASS_EN
    l0 = m_look(bus.q0_addr);
    l1 = m_look(bus.q1_addr);
`else
    l0 = 17'd0;
    l1 = 17'd0;
`endif
    chk("q0_hit",  {31'd0, bus.q0_hit}, {31'd0, l0[DW]});
    chk("q0_data", 32'(bus.q0_data),    32'(l0[DW-1:0]));
    chk("q1_hit",  {31'd0, bus.q1_hit}, {31'd0, l1[DW]});
    chk("q1_data", 32'(bus.q1_data),    32'(l1[DW-1:0]));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ent(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int writes;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = 4'd0;
    bus.in_data  = 16'd0;
    bus.wb_stall = 1'b0;
    bus.q0_addr  = 4'd0;
    bus.q1_addr  = 4'd0;
    bus.hlt      = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_count",    32'(bus.count),        32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_we",       {31'd0, bus.we},       32'd0);
    chk("rst_drained",  {31'd0, bus.drained},  32'd0);
    chk("rst_dst",      32'(bus.dst),          32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single write
    bus.in_valid = 1'b1; bus.in_addr = 4'd3; bus.in_data = 16'h1234;
    @(negedge clk);
    chk("sw_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sw_we",   {31'd0, bus.we},  32'd1);
    chk("sw_addr", 32'(bus.dst_addr), 32'd3);
    chk("sw_data", 32'(bus.dst),      32'h1234);
    tick();
    @(negedge clk);
    chk("sw_empty", 32'(bus.count), 32'd0);
    chk("sw_we0",   {31'd0, bus.we}, 32'd0);

    // fill under stall, then push/pop while full
    tick();
    bus.wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) push_ent(4'(i + 1), 16'hA000 + 16'(i));
    @(negedge clk);
    chk("full_count", 32'(bus.count),        32'd4);
    chk("full_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.wb_stall = 1'b0;
    bus.in_valid = 1'b1; bus.in_addr = 4'd6; bus.in_data = 16'hB006;
    @(negedge clk);
    chk("pp_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("pp_head1", 32'(bus.dst_addr),     32'd1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pp_count", 32'(bus.count),    32'd4);
    chk("pp_head2", 32'(bus.dst_addr), 32'd2);
    chk("pp_data2", 32'(bus.dst),      32'hA001);
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk);
    chk("fill_drained", 32'(bus.count), 32'd0);

    // forwarding
    tick();
    bus.wb_stall = 1'b1;
    push_ent(4'd5, 16'h0001);
    push_ent(4'd5, 16'h0002);
    bus.q0_addr = 4'd5;
    bus.q1_addr = 4'd0;
    @(negedge clk);
`ifdef RF_WB_BYPASS_EN
    chk("fw_hit",  {31'd0, bus.q0_hit}, 32'd1);
    chk("fw_data", 32'(bus.q0_data),    32'h0002);
`else
    chk("fw_hit",  {31'd0, bus.q0_hit}, 32'd0);
    chk("fw_data", 32'(bus.q0_data),    32'h0000);
`endif
    chk("fw_r0", {31'd0, bus.q1_hit}, 32'd0);
    tick();
    bus.wb_stall = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // R0 write is accepted but dropped
    bus.in_valid = 1'b1; bus.in_addr = 4'd0; bus.in_data = 16'hFFFF;
    @(negedge clk);
    chk("r0_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("r0_count", 32'(bus.count), 32'd0);
    chk("r0_we",    {31'd0, bus.we}, 32'd0);

    // halt drain with 3 queued entries
    tick();
    bus.wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) push_ent(4'(i + 1), 16'hC000 + 16'(i));
    bus.wb_stall = 1'b0;
    bus.hlt = 1'b1;
    writes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.drained) break;
      if (bus.we) writes++;
      tick();
    end
    chk("halt_drained", {31'd0, bus.drained},  32'd1);
    chk("halt_writes",  32'(writes),           32'd3);
    chk("halt_ready",   {31'd0, bus.in_ready}, 32'd0);
    bus.hlt = 1'b0;
    tick();
    @(negedge clk);
    chk("resume_ready",   {31'd0, bus.in_ready}, 32'd1);
    chk("resume_drained", {31'd0, bus.drained},  32'd0);

    // reset while entries are pending
    tick();
    bus.wb_stall = 1'b1;
    push_ent(4'd7, 16'h7777);
    push_ent(4'd8, 16'h8888);
    bus.wb_stall = 1'b0;
    #1;
    chk("mid_we_pre", {31'd0, bus.we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_we_async", {31'd0, bus.we}, 32'd0);
    chk("mid_count",    32'(bus.count),  32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_we", {31'd0, bus.we}, 32'd0);
      tick();
    end

    // randomized phase
    for (int c = 0; c < 2000; c++) begin
      bus.in_valid = ($urandom_range(0, 99) < 60);
      bus.in_addr  = 4'($urandom_range(0, 7));
      bus.in_data  = 16'($urandom);
      bus.wb_stall = ($urandom_range(0, 99) < 30);
      bus.q0_addr  = 4'($urandom_range(0, 7));
      bus.q1_addr  = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 3) bus.hlt = ~bus.hlt;
      if (c == 1000) rst_n = 1'b0;
      if (c == 1003) rst_n = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.hlt = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
